bdr_ctx_engine: RTL and testbench

Context save/restore engine that acts as the initiator on the BDR register-bank port. On command it either streams all bank registers out as bytes (save) or accepts a byte stream and writes it into the bank (restore). It sits between the BDR and a debug or context-switch controller, and drives the BDR's `reg_write`/`write_dest`/`write_data`/`read1` inputs.

---
 rtl/bdr_ctx_if.sv | 36 +++
 rtl/bdr_ctx_engine.sv | 111 +++++++++++
 tb/tb_bdr_ctx_engine.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bdr_ctx_if.sv
// Bundle of command, bank-port and byte-stream signals for the BDR context engine.
// Every valid/ready pair transfers on a cycle where both are high at the rising edge;
// a raised valid stays high, with its payload held stable, until that transfer happens.
interface bdr_ctx_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic          busy;
  logic          done;
  logic          reg_write;
  logic [AW-1:0] write_dest;
  logic [DW-1:0] write_data;
  logic [AW-1:0] read1;
  logic [DW-1:0] read_data1;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;

  modport master (
    input  cmd_valid, cmd_op, read_data1, out_ready, in_valid, in_data,
    output cmd_ready, busy, done, reg_write, write_dest, write_data, read1,
           out_valid, out_data, in_ready
  );

  modport slave (
    output cmd_valid, cmd_op, read_data1, out_ready, in_valid, in_data,
    input  cmd_ready, busy, done, reg_write, write_dest, write_data, read1,
           out_valid, out_data, in_ready
  );
endinterface

// File: rtl/bdr_ctx_engine.sv
// Context save/restore engine: streams the BDR bank out as bytes (save) or
// writes an incoming byte stream into the bank (restore).
module bdr_ctx_engine #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int DW   = 8
) (
  input  logic       i_clock,
  input  logic       i_reset,
  bdr_ctx_if.master  bus,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SAVE_LOAD = 3'd1,
    S_SAVE_WAIT = 3'd2,
    S_RESTORE   = 3'd3,
    S_FIN       = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_idx;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic          r_reg_write;
  logic [AW-1:0] r_write_dest;
  logic [DW-1:0] r_write_data;

  logic w_cmd_fire;
  logic w_out_fire;
  logic w_in_fire;
  logic w_last;

  assign w_cmd_fire = (r_state == S_IDLE) && bus.cmd_valid;
  assign w_out_fire = (r_state == S_SAVE_WAIT) && r_out_valid && bus.out_ready;
  assign w_in_fire  = (r_state == S_RESTORE) && bus.in_valid;
  // Terminal index test stops idx at NREG-1, so it never wraps.
  assign w_last     = (r_idx == AW'(NREG - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_cmd_fire) w_next = bus.cmd_op ? S_RESTORE : S_SAVE_LOAD;
      S_SAVE_LOAD: w_next = S_SAVE_WAIT;
      S_SAVE_WAIT: if (w_out_fire) w_next = w_last ? S_FIN : S_SAVE_LOAD;
      S_RESTORE:   if (w_in_fire && w_last) w_next = S_FIN;
      S_FIN:       w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_idx        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_reg_write  <= 1'b0;
      r_write_dest <= '0;
      r_write_data <= '0;
    end else begin
      // Bank write strobe lasts exactly the cycle after each accepted byte.
      r_reg_write <= w_in_fire;
      if (w_in_fire) begin
        r_write_dest <= r_idx;
        r_write_data <= bus.in_data;
      end
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) r_idx <= '0;
        end
        S_SAVE_LOAD: begin
          r_out_data  <= bus.read_data1;
          r_out_valid <= 1'b1;
        end
        S_SAVE_WAIT: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            if (!w_last) r_idx <= r_idx + AW'(1);
          end
        end
        S_RESTORE: begin
          if (w_in_fire && !w_last) r_idx <= r_idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready  = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = (r_state == S_FIN);
  assign bus.in_ready   = (r_state == S_RESTORE);
  assign bus.read1      = r_idx;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.reg_write  = r_reg_write;
  assign bus.write_dest = r_write_dest;
  assign bus.write_data = r_write_data;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_bdr_ctx_engine.sv
// Self-checking bench for bdr_ctx_engine: a behavioural BDR bank plus a reference
// model of bank contents, expected save stream and expected restore writes.
module tb_bdr_ctx_engine;
  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int DW   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bdr_ctx_if #(.AW(AW), .DW(DW)) bif ();
  logic [2:0] dbg_state;

  bdr_ctx_engine #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .bus         (bif.master),
    .o_dbg_state (dbg_state)
  );

  // ---------------- BDR bank (not reset: survives engine reset) ----------------
  logic [DW-1:0] bank     [NREG];
  logic [DW-1:0] pre_bank [NREG];
  logic          preload = 1'b0;

  always @(posedge clk) begin
    if (preload) bank <= pre_bank;
    else if (bif.reg_write) bank[bif.write_dest] <= bif.write_data;
  end
  assign bif.read_data1 = bank[bif.read1];

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0]    model_bank [NREG];
  logic [DW-1:0]    exp_q [$];
  logic [AW+DW-1:0] wr_q  [$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"}, 32'(bif.cmd_ready), 32'd1);
    check({tag, "_busy"},      32'(bif.busy),      32'd0);
    check({tag, "_done"},      32'(bif.done),      32'd0);
    check({tag, "_reg_write"}, 32'(bif.reg_write), 32'd0);
    check({tag, "_out_valid"}, 32'(bif.out_valid), 32'd0);
    check({tag, "_in_ready"},  32'(bif.in_ready),  32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_idle(tag);
    check({tag, "_write_dest"}, 32'(bif.write_dest), 32'd0);
    check({tag, "_write_data"}, 32'(bif.write_data), 32'd0);
    check({tag, "_read1"},      32'(bif.read1),      32'd0);
    check({tag, "_out_data"},   32'(bif.out_data),   32'd0);
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < NREG; i++) check(tag, 32'(bank[i]), 32'(model_bank[i]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload_bank(input bit rnd, input logic [DW-1:0] base);
    @(negedge clk);
    for (int i = 0; i < NREG; i++) pre_bank[i] = rnd ? DW'($urandom) : base + DW'(i);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    for (int i = 0; i < NREG; i++) model_bank[i] = pre_bank[i];
  endtask

  // mode 0: stall stall_n cycles on byte stall_byte; mode 1: random backpressure
  task automatic do_save(input int mode, input int stall_byte, input int stall_n);
    int t, done_t, first_t, nstall, byte_i, stall_left;
    bit rw_seen, stalled_prev, rdy;
    logic [DW-1:0] prev_data;
    exp_q.delete();
    for (int i = 0; i < NREG; i++) exp_q.push_back(model_bank[i]);
    t = 0; done_t = -1; first_t = -1; nstall = 0; byte_i = 0;
    stall_left = stall_n; rw_seen = 0; stalled_prev = 0; prev_data = '0;
    bif.cmd_valid = 1'b1; bif.cmd_op = 1'b0; bif.out_ready = 1'b1;
    while (t < 400) begin
      @(negedge clk);
      t++;
      bif.cmd_valid = 1'b0;
      if (bif.reg_write) rw_seen = 1;
      if (bif.done) begin done_t = t; break; end
      if (stalled_prev) begin
        check("save_hold_valid", 32'(bif.out_valid), 32'd1);
        check("save_hold_data",  32'(bif.out_data),  32'(prev_data));
      end
      if (bif.out_valid) begin
        if (first_t < 0) first_t = t;
        if (mode == 0) begin
          rdy = !(byte_i == stall_byte && stall_left > 0);
          if (!rdy) stall_left--;
        end else begin
          rdy = ($urandom_range(0, 3) != 0);
        end
        bif.out_ready = rdy;
        if (rdy) begin
          if (exp_q.size() == 0) check("save_extra_byte", 32'd1, 32'd0);
          else check("save_byte", 32'(bif.out_data), 32'(exp_q.pop_front()));
          byte_i++;
          stalled_prev = 0;
        end else begin
          nstall++;
          stalled_prev = 1;
          prev_data = bif.out_data;
        end
      end else begin
        stalled_prev = 0;
        bif.out_ready = 1'($urandom_range(0, 1));
      end
    end
    bif.out_ready = 1'b1;
    check("save_timeout", 32'(done_t > 0), 32'd1);
    check("save_first_valid_cycle", 32'(first_t), 32'd2);
    if (mode == 0) check("save_stall_count", 32'(nstall), 32'(stall_n));
    check("save_done_cycle", 32'(done_t), 32'(2 * NREG + 1 + nstall));
    check("save_bytes_left", 32'(exp_q.size()), 32'd0);
    check("save_no_reg_write", 32'(rw_seen), 32'd0);
    @(negedge clk);
    check_idle("save_end");
  endtask

  // gap_mode 0: contiguous A0+i, 1: alternate cycles, 2: random gaps
  task automatic do_restore(input int gap_mode, input int abort_after, input bit poke_cmd);
    int t, done_t, last_acc, sent;
    bit v;
    logic [DW-1:0] d;
    logic [AW+DW-1:0] e;
    wr_q.delete();
    t = 0; done_t = -1; last_acc = -1; sent = 0;
    bif.cmd_valid = 1'b1; bif.cmd_op = 1'b1; bif.in_valid = 1'b0;
    while (t < 400) begin
      @(negedge clk);
      t++;
      bif.cmd_valid = 1'b0;
      bif.in_valid  = 1'b0;
      if (bif.reg_write) begin
        if (wr_q.size() == 0) check("restore_extra_write", 32'd1, 32'd0);
        else begin
          e = wr_q.pop_front();
          check("restore_dest", 32'(bif.write_dest), 32'(e[DW +: AW]));
          check("restore_data", 32'(bif.write_data), 32'(e[DW-1:0]));
        end
      end
      if (bif.done) begin done_t = t; break; end
      if (abort_after > 0 && sent == abort_after) begin
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("abort");
        rst = 1'b0;
        check_bank("abort_bank");
        return;
      end
      check("restore_in_ready", 32'(bif.in_ready), 32'd1);
      if (poke_cmd && t == 3) begin
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = 1'b0;
        check("restore_cmd_ready", 32'(bif.cmd_ready), 32'd0);
        check("restore_busy",      32'(bif.busy),      32'd1);
      end
      if (sent < NREG) begin
        case (gap_mode)
          0: v = 1;
          1: v = (t % 2) == 1;
          default: v = ($urandom_range(0, 2) != 0);
        endcase
        d = (gap_mode == 0) ? 8'hA0 + DW'(sent) : DW'($urandom);
        bif.in_valid = v;
        bif.in_data  = d;
        if (v) begin
          wr_q.push_back({AW'(sent), d});
          model_bank[sent] = d;
          sent++;
          last_acc = t;
        end
      end
    end
    bif.in_valid = 1'b0;
    check("restore_timeout", 32'(done_t > 0), 32'd1);
    check("restore_done_cycle", 32'(done_t), 32'(last_acc + 1));
    if (gap_mode == 0) check("restore_done_c9", 32'(done_t), 32'(NREG + 1));
    check("restore_writes_left", 32'(wr_q.size()), 32'd0);
    @(negedge clk);
    check_idle("restore_end");
    check_bank("restore_bank");
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    bif.cmd_valid = 1'b0; bif.cmd_op = 1'b0; bif.out_ready = 1'b1;
    bif.in_valid = 1'b0; bif.in_data = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;

    preload_bank(0, 8'h10);
    do_save(0, -1, 0);
    do_save(0, 3, 3);

    do_restore(0, 0, 0);
    do_save(0, -1, 0);

    do_restore(1, 0, 1);
    do_save(1, -1, 0);

    // reset while a save is in flight
    bif.cmd_valid = 1'b1; bif.cmd_op = 1'b0; bif.out_ready = 1'b0;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_mid_save");
    rst = 1'b0;
    bif.out_ready = 1'b1;

    preload_bank(1, '0);
    do_restore(2, 3, 0);
    @(negedge clk);
    check_idle("post_abort");
    do_save(1, -1, 0);

    for (int r = 0; r < 3; r++) begin
      do_restore(2, 0, 0);
      do_save(1, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
